// File: rtl/mux_32bit_pkg.sv
// Shared types and constants for the 32-bit word selector.
// Optional feature macro: MUX_32BIT_PARITY_EN (adds a registered even-parity bit).
package mux_32bit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [31:0] word_t;

  // Value the registered copy takes while reset is asserted.
  localparam word_t WORD_ZERO = 32'h0;

endpackage : mux_32bit_pkg

// File: rtl/mux_32bit_reg.sv
// Registered copy of the selected word, with asynchronous active-high reset.
// Optional feature macro: MUX_32BIT_PARITY_EN (adds par, the even parity of q).
// There is no handshake here: d is captured unconditionally on every rising clk edge.
module mux_32bit_reg
  import mux_32bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef MUX_32BIT_PARITY_EN
  ,
  output logic             par
`endif
);

  // Capture the selected word each cycle; reset clears it at once, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= WIDTH'(WORD_ZERO);
    end else begin
      q <= d;
    end
  end

`ifdef MUX_32BIT_PARITY_EN
  // Parity is computed from d so it lands in the same cycle as the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else begin
      par <= ^d;
    end
  end
`endif

endmodule : mux_32bit_reg

// File: rtl/mux_32bit.sv
// Two-input word selector for the single-cycle datapath.
// out is purely combinational; out_q is a one-cycle registered copy of out.
// Optional feature macro: MUX_32BIT_PARITY_EN (adds out_par = even parity of out_q).
// No valid/ready handshake: inputs are consumed continuously and out_q samples every edge.
module mux_32bit
  import mux_32bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
`ifdef MUX_32BIT_PARITY_EN
  ,
  output logic             out_par
`endif
);

  // Continuous select; the ?: operator gives a bitwise merge when select is unknown in sim.
  assign out = select ? inp2 : inp1;

  mux_32bit_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk (clk),
    .rst (rst),
    .d   (out),
    .q   (out_q)
`ifdef MUX_32BIT_PARITY_EN
    ,
    .par (out_par)
`endif
  );

endmodule : mux_32bit

// File: tb/tb_mux_32bit.sv
// Directed testbench for mux_32bit: combinational select, registered copy, async reset,
// and (when MUX_32BIT_PARITY_EN is defined) the parity bit.
module tb_mux_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inp1 = 32'h0;
  logic [31:0] inp2 = 32'h0;
  logic        select = 1'b0;
  logic [31:0] out;
  logic [31:0] out_q;
`ifdef MUX_32BIT_PARITY_EN
  logic        out_par;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  mux_32bit #(
    .WIDTH(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inp1   (inp1),
    .inp2   (inp2),
    .select (select),
    .out    (out),
    .out_q  (out_q)
`ifdef MUX_32BIT_PARITY_EN
    ,
    .out_par(out_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Directed vectors for the lag test: {select, inp1, inp2, expected out}
  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] prev_q;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{1'b0, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 32'h8000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFE};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("reset_out_q", out_q, 32'h0);
    check("reset_out", out, 32'h0);
`ifdef MUX_32BIT_PARITY_EN
    check("reset_par", {31'b0, out_par}, 32'h0);
`endif

    // 1: select=0 picks inp1, no clock needed
    inp1 = 32'h5F5F_5F5F; inp2 = 32'h0; select = 1'b0;
    #1;
    check("t1_out_inp1", out, 32'h5F5F_5F5F);

    // 2: swap data and select
    inp1 = 32'h0; inp2 = 32'h5F5F_5F5F; select = 1'b1;
    #1;
    check("t2_out_inp2", out, 32'h5F5F_5F5F);
    check("t2_rst_holds_q", out_q, 32'h0);

    // 3: toggle select
    inp1 = 32'hFFFF_FFFF; inp2 = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      select = i[0];
      #1;
      check("t3_toggle", out, (i[0] ? 32'h0000_0001 : 32'hFFFF_FFFF));
    end

    // Release reset and load DEADBEEF into out_q
    @(negedge clk);
    rst = 1'b0;
    inp1 = 32'hDEAD_BEEF; select = 1'b0;
    @(posedge clk); #1;
    check("load_q", out_q, 32'hDEAD_BEEF);

    // 4: async reset mid-cycle
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t4_async_q", out_q, 32'h0);
    check("t4_out_kept", out, 32'hDEAD_BEEF);
`ifdef MUX_32BIT_PARITY_EN
    check("t4_par_rst", {31'b0, out_par}, 32'h0);
`endif
    rst = 1'b0;
    #1;
    check("t4_q_wait_edge", out_q, 32'h0);
    @(posedge clk); #1;
    check("t4_q_after_edge", out_q, 32'hDEAD_BEEF);
`ifdef MUX_32BIT_PARITY_EN
    check("t4_par_deadbeef", {31'b0, out_par}, 32'h0);
`endif

    // 5: one-cycle lag, including simultaneous select and data changes
    prev_q = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      select = vecs[i].sel; inp1 = vecs[i].a; inp2 = vecs[i].b;
      #1;
      check("t5_out", out, vecs[i].exp);
      check("t5_q_lag", out_q, prev_q);
      @(posedge clk); #1;
      check("t5_q_capture", out_q, vecs[i].exp);
      prev_q = vecs[i].exp;
    end

`ifdef MUX_32BIT_PARITY_EN
    // 6: parity of the registered word
    @(negedge clk);
    select = 1'b0; inp1 = 32'h0000_0007;
    @(posedge clk); #1;
    check("t6_q7", out_q, 32'h0000_0007);
    check("t6_par7", {31'b0, out_par}, 32'h1);
    @(negedge clk);
    inp1 = 32'h0000_0003;
    #1;
    check("t6_par_lag", {31'b0, out_par}, 32'h1);
    @(posedge clk); #1;
    check("t6_par3", {31'b0, out_par}, 32'h0);
    @(negedge clk);
    inp1 = 32'h0000_0007;
    @(posedge clk); #1;
    check("t6_par7b", {31'b0, out_par}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_par_async_rst", {31'b0, out_par}, 32'h0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the directed sequence is short; stop if it somehow stalls.
  initial begin
    #5000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mux_32bit
